// File: rtl/cache_mem_arbiter.sv
// Shares one multi-cycle main memory among I-cache fills, D-cache fills and D-cache stores.
// Optional CACHE_ARB_RR_EN: round-robin between I and D sides instead of fixed D-first priority.
module cache_mem_arbiter #(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned WORDS  = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_req,
  input  logic [ADDR_W-1:0]        i_addr,
  input  logic                     d_req,
  input  logic [ADDR_W-1:0]        d_addr,
  input  logic                     d_wr,
  input  logic [ADDR_W-1:0]        d_wr_addr,
  input  logic [15:0]              d_wr_data,
  output logic                     mem_en,
  output logic                     mem_we,
  output logic [ADDR_W-1:0]        mem_addr,
  output logic [15:0]              mem_wdata,
  input  logic [15:0]              mem_rdata,
  input  logic                     mem_rvalid,
  output logic [15:0]              fill_data,
  output logic [$clog2(WORDS)-1:0] fill_word,
  output logic                     i_fill_we,
  output logic                     d_fill_we,
  output logic                     i_done,
  output logic                     d_done,
  output logic                     d_wr_ack,
  output logic                     i_busy,
  output logic                     d_busy
);

  localparam int unsigned WW = $clog2(WORDS);
  localparam logic [ADDR_W-1:0] BaseMask = ~ADDR_W'(2 * WORDS - 1);
  localparam logic [WW-1:0] LastWord = WW'(WORDS - 1);

  typedef enum logic [1:0] {StIdle, StIFill, StDFill, StDWrite} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [WW-1:0]     iss_q, iss_d;
  logic              iss_all_q, iss_all_d;
  logic [WW-1:0]     rcv_q, rcv_d;
  logic              pend_d, grant_d;

  assign pend_d    = d_wr | d_req;
  assign fill_data = mem_rdata;

`ifdef CACHE_ARB_RR_EN
  // Set when the D side won the last grant; the I side is then favoured on a tie.
  logic last_d_q, last_d_d;

  assign grant_d = pend_d & (~i_req | ~last_d_q);

  always_comb begin
    last_d_d = last_d_q;
    if (state_q == StIdle && (pend_d || i_req)) begin
      last_d_d = grant_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      last_d_q <= 1'b0;
    end else begin
      last_d_q <= last_d_d;
    end
  end
`else
  assign grant_d = pend_d;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      base_q    <= '0;
      iss_q     <= '0;
      iss_all_q <= 1'b0;
      rcv_q     <= '0;
    end else begin
      state_q   <= state_d;
      base_q    <= base_d;
      iss_q     <= iss_d;
      iss_all_q <= iss_all_d;
      rcv_q     <= rcv_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    base_d    = base_q;
    iss_d     = iss_q;
    iss_all_d = iss_all_q;
    rcv_d     = rcv_q;
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    fill_word = '0;
    i_fill_we = 1'b0;
    d_fill_we = 1'b0;
    i_done    = 1'b0;
    d_done    = 1'b0;
    d_wr_ack  = 1'b0;

    case (state_q)
      StIdle: begin
        iss_d     = '0;
        iss_all_d = 1'b0;
        rcv_d     = '0;
        if (grant_d) begin
          if (d_wr) begin
            state_d = StDWrite;
          end else begin
            state_d = StDFill;
            base_d  = d_addr & BaseMask;
          end
        end else if (i_req) begin
          state_d = StIFill;
          base_d  = i_addr & BaseMask;
        end
      end

      StIFill, StDFill: begin
        if (!iss_all_q) begin
          mem_en   = 1'b1;
          mem_addr = base_q + ADDR_W'({iss_q, 1'b0});
          iss_d    = iss_q + WW'(1);
          if (iss_q == LastWord) begin
            iss_all_d = 1'b1;
          end
        end
        if (mem_rvalid) begin
          fill_word = rcv_q;
          i_fill_we = (state_q == StIFill);
          d_fill_we = (state_q == StDFill);
          if (rcv_q == LastWord) begin
            i_done    = (state_q == StIFill);
            d_done    = (state_q == StDFill);
            state_d   = StIdle;
            rcv_d     = '0;
            iss_d     = '0;
            iss_all_d = 1'b0;
          end else begin
            rcv_d = rcv_q + WW'(1);
          end
        end
      end

      StDWrite: begin
        mem_en    = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = d_wr_addr;
        mem_wdata = d_wr_data;
        d_wr_ack  = 1'b1;
        state_d   = StIdle;
      end

      default: state_d = StIdle;
    endcase

    i_busy = i_req & ~i_done;
    d_busy = (d_req & ~d_done) | (d_wr & ~d_wr_ack);
  end

endmodule
